// File: rtl/wb_team_sequencer_if.sv
// Host-side Wishbone bus between the Caravel slave port and the team sequencer.
// Signal names follow the host port, so "_i" is host-to-sequencer and "_o" is sequencer-to-host.
interface wb_team_sequencer_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_adr_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_adr_i,
        output wbs_ack_o,
        output wbs_dat_o
    );
endinterface

// File: rtl/wb_team_sequencer.sv
// Registered Wishbone sequencer: decodes one target per host request, strobes it, and answers
// the host itself on ack, on timeout (so a hung team cannot stall the bus) or for unmapped space.
module wb_team_sequencer #(
    parameter int          NUM_TEAMS     = 1,
    parameter int          TIMEOUT_CYC   = 256,
    parameter logic [31:0] UNMAPPED_DATA = 32'hBAD0ADD5,
    parameter logic [31:0] TIMEOUT_DATA  = 32'hDEAD0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    wb_team_sequencer_if.slave      wbs,
    output logic                    la_control_stb,
    output logic                    gpio_control_stb,
    output logic [NUM_TEAMS-1:0]    designs_stb,
    output logic [31:0]             adr_truncated,
    input  logic                    la_control_ack_i,
    input  logic [31:0]             la_control_dat_i,
    input  logic                    gpio_control_ack_i,
    input  logic [31:0]             gpio_control_dat_i,
    input  logic [NUM_TEAMS-1:0]    designs_ack_i,
    input  logic [32*NUM_TEAMS-1:0] designs_dat_i,
    output logic [7:0]              timeout_cnt
);

    localparam int            TW             = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TIMER_LAST     = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    FIRST_UNMAPPED = 8'(NUM_TEAMS + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [7:0]    target_idx_r;
    logic [7:0]    req_sel_s;
    logic          sel_ack_s;
    logic [31:0]   sel_dat_s;
    logic          unused_adr_s;

    // One-hot team strobe for a decode value; all zero for LA, GPIO or unmapped.
    function automatic logic [NUM_TEAMS-1:0] team_mask(input logic [7:0] sel);
        logic [NUM_TEAMS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_TEAMS; i++) begin
            if (sel == 8'(i + 2)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    assign req_sel_s    = wbs.wbs_adr_i[23:16];
    assign unused_adr_s = ^wbs.wbs_adr_i[31:24];

    // Ack/data of the latched target only; every other target's ack is ignored.
    always_comb begin
        sel_ack_s = 1'b0;
        sel_dat_s = 32'h0000_0000;
        case (target_idx_r)
            8'd0: begin
                sel_ack_s = la_control_ack_i;
                sel_dat_s = la_control_dat_i;
            end
            8'd1: begin
                sel_ack_s = gpio_control_ack_i;
                sel_dat_s = gpio_control_dat_i;
            end
            default: begin
                for (int i = 0; i < NUM_TEAMS; i++) begin
                    if (target_idx_r == 8'(i + 2)) begin
                        sel_ack_s = designs_ack_i[i];
                        sel_dat_s = designs_dat_i[32*i +: 32];
                    end else begin
                        sel_ack_s = sel_ack_s;
                        sel_dat_s = sel_dat_s;
                    end
                end
            end
        endcase
    end

    // Transaction FSM with all target strobes and the host response registered.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r          <= IDLE;
            timer_r          <= '0;
            target_idx_r     <= 8'd0;
            adr_truncated    <= 32'h0000_0000;
            la_control_stb   <= 1'b0;
            gpio_control_stb <= 1'b0;
            designs_stb      <= '0;
            wbs.wbs_ack_o    <= 1'b0;
            wbs.wbs_dat_o    <= 32'h0000_0000;
            timeout_cnt      <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    wbs.wbs_ack_o <= 1'b0;
                    wbs.wbs_dat_o <= 32'h0000_0000;
                    if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                        target_idx_r  <= req_sel_s;
                        adr_truncated <= {16'h0000, wbs.wbs_adr_i[15:0]};
                        timer_r       <= '0;
                        if (req_sel_s < FIRST_UNMAPPED) begin
                            la_control_stb   <= (req_sel_s == 8'd0);
                            gpio_control_stb <= (req_sel_s == 8'd1);
                            designs_stb      <= team_mask(req_sel_s);
                            state_r          <= BUSY;
                        end else begin
                            // Unmapped space is answered locally without touching any target.
                            wbs.wbs_ack_o <= 1'b1;
                            wbs.wbs_dat_o <= UNMAPPED_DATA;
                            state_r       <= RESP;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (sel_ack_s) begin
                        la_control_stb   <= 1'b0;
                        gpio_control_stb <= 1'b0;
                        designs_stb      <= '0;
                        wbs.wbs_ack_o    <= 1'b1;
                        wbs.wbs_dat_o    <= sel_dat_s;
                        state_r          <= RESP;
                    end else if (timer_r == TIMER_LAST) begin
                        la_control_stb   <= 1'b0;
                        gpio_control_stb <= 1'b0;
                        designs_stb      <= '0;
                        wbs.wbs_ack_o    <= 1'b1;
                        wbs.wbs_dat_o    <= {TIMEOUT_DATA[31:8], target_idx_r};
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end else begin
                            timeout_cnt <= timeout_cnt;
                        end
                        state_r <= RESP;
                    end else if (!wbs.wbs_cyc_i) begin
                        // Host abandoned the cycle: release the target silently.
                        la_control_stb   <= 1'b0;
                        gpio_control_stb <= 1'b0;
                        designs_stb      <= '0;
                        state_r          <= IDLE;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                RESP: begin
                    wbs.wbs_ack_o <= 1'b0;
                    wbs.wbs_dat_o <= 32'h0000_0000;
                    state_r       <= IDLE;
                end
                default: begin
                    la_control_stb   <= 1'b0;
                    gpio_control_stb <= 1'b0;
                    designs_stb      <= '0;
                    wbs.wbs_ack_o    <= 1'b0;
                    wbs.wbs_dat_o    <= 32'h0000_0000;
                    state_r          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_team_sequencer.sv
// Scoreboard bench for wb_team_sequencer with two team slots and a 16-cycle timeout.
module tb_wb_team_sequencer;

    localparam logic [31:0] LA_DAT   = 32'h0000_1234;
    localparam logic [31:0] GPIO_DAT = 32'h0000_6710;
    localparam logic [31:0] T1_DAT   = 32'h7EA0_0001;
    localparam logic [31:0] T2_DAT   = 32'h7EA0_0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        la_stb, gpio_stb;
    logic [1:0]  designs_stb;
    logic [31:0] adr_trunc;
    logic [7:0]  tcnt;
    logic        la_ack_r, gpio_ack_r;
    logic [1:0]  team_ack_r;
    logic        la_en = 1'b0, gpio_en = 1'b0, gpio_force = 1'b0;
    logic [1:0]  team_en = 2'b00, team_force = 2'b00;
    logic        gpio_ack;
    logic [1:0]  team_ack;

    int checks = 0;
    int errors = 0;
    int ack_total = 0, la_cyc = 0, gpio_cyc = 0, t0_cyc = 0, t1_cyc = 0;
    logic [31:0] exp_q[$];

    wb_team_sequencer_if bus();

    always #5 clk = ~clk;

    assign gpio_ack = gpio_ack_r | gpio_force;
    assign team_ack = team_ack_r | team_force;

    wb_team_sequencer #(
        .NUM_TEAMS    (2),
        .TIMEOUT_CYC  (16),
        .UNMAPPED_DATA(32'hBAD0ADD5),
        .TIMEOUT_DATA (32'hDEAD0000)
    ) dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .wbs               (bus.slave),
        .la_control_stb    (la_stb),
        .gpio_control_stb  (gpio_stb),
        .designs_stb       (designs_stb),
        .adr_truncated     (adr_trunc),
        .la_control_ack_i  (la_ack_r),
        .la_control_dat_i  (LA_DAT),
        .gpio_control_ack_i(gpio_ack),
        .gpio_control_dat_i(GPIO_DAT),
        .designs_ack_i     (team_ack),
        .designs_dat_i     ({T2_DAT, T1_DAT}),
        .timeout_cnt       (tcnt)
    );

    // Registered targets: ack one cycle after seeing their strobe, when enabled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            la_ack_r   <= 1'b0;
            gpio_ack_r <= 1'b0;
            team_ack_r <= 2'b00;
        end else begin
            la_ack_r   <= la_en & la_stb & ~la_ack_r;
            gpio_ack_r <= gpio_en & gpio_stb & ~gpio_ack_r;
            team_ack_r <= team_en & designs_stb & ~team_ack_r;
        end
    end

    // Activity counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wbs_ack_o) ack_total++;
        if (la_stb) la_cyc++;
        if (gpio_stb) gpio_cyc++;
        if (designs_stb[0]) t0_cyc++;
        if (designs_stb[1]) t1_cyc++;
    end

    // Issue one request (called just after a posedge), then pop and compare on host ack.
    task automatic do_req(input logic [31:0] a, input logic [31:0] exp_dat, input int exp_edge,
                          input bit keep, input string name);
        int n;
        bit seen;
        logic [31:0] exp_v;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = a;
        exp_q.push_back(exp_dat);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.wbs_ack_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_ack got none want one within 400 cycles", name);
            exp_q.delete();
        end else begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.wbs_dat_o !== exp_v) begin
                errors++;
                $display("FAIL %s_dat got %h want %h", name, bus.wbs_dat_o, exp_v);
            end
            if (exp_edge >= 0) begin
                checks++;
                if ((n - 2) !== exp_edge) begin
                    errors++;
                    $display("FAIL %s_latency got %0d want %0d", name, n - 2, exp_edge);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.wbs_ack_o, bus.wbs_dat_o} !== 33'd0) begin
            errors++;
            $display("FAIL %s_ack_pulse got ack=%b dat=%h want 0/0", name, bus.wbs_ack_o, bus.wbs_dat_o);
        end
        if (!keep) begin
            bus.wbs_cyc_i = 1'b0;
            bus.wbs_stb_i = 1'b0;
        end
    endtask

    // Start a team-1 request and wait (bounded) for its strobe at a negedge.
    task automatic start_team1(output bit found);
        int n;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = 32'h3002_0004;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            if (designs_stb[0] === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_adr_i = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({la_stb, gpio_stb, designs_stb, bus.wbs_ack_o, bus.wbs_dat_o, tcnt, adr_trunc} !== 77'd0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero (ack=%b dat=%h cnt=%h) want all 0",
                     bus.wbs_ack_o, bus.wbs_dat_o, tcnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_la_read();
        int l0, g0, a0, b0;
        l0 = la_cyc; g0 = gpio_cyc; a0 = t0_cyc; b0 = t1_cyc;
        la_en = 1'b1;
        do_req(32'h3000_0010, LA_DAT, 2, 1'b0, "la");
        la_en = 1'b0;
        checks++;
        if (adr_trunc !== 32'h0000_0010) begin
            errors++;
            $display("FAIL la_adr_truncated got %h want 00000010", adr_trunc);
        end
        checks++;
        if ((la_cyc - l0) !== 2 || gpio_cyc !== g0 || t0_cyc !== a0 || t1_cyc !== b0) begin
            errors++;
            $display("FAIL la_strobes got la=%0d others=%0d want la=2 others=0",
                     la_cyc - l0, (gpio_cyc - g0) + (t0_cyc - a0) + (t1_cyc - b0));
        end
    endtask

    task automatic test_unmapped();
        int s0;
        s0 = la_cyc + gpio_cyc + t0_cyc + t1_cyc;
        do_req(32'h30FF_0000, 32'hBAD0ADD5, 0, 1'b0, "unmapped");
        checks++;
        if ((la_cyc + gpio_cyc + t0_cyc + t1_cyc) !== s0) begin
            errors++;
            $display("FAIL unmapped_strobes got %0d want 0", la_cyc + gpio_cyc + t0_cyc + t1_cyc - s0);
        end
        checks++;
        if (adr_trunc !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_adr_truncated got %h want 00000000", adr_trunc);
        end
    endtask

    task automatic test_team2_and_gpio();
        int a0, b0;
        a0 = t0_cyc; b0 = t1_cyc;
        team_en = 2'b11;
        do_req(32'h3003_0008, T2_DAT, 2, 1'b0, "team2");
        team_en = 2'b00;
        checks++;
        if ((t1_cyc - b0) !== 2 || t0_cyc !== a0 || adr_trunc !== 32'h8) begin
            errors++;
            $display("FAIL team2_strobe got t2=%0d t1=%0d adr=%h want 2/0/00000008",
                     t1_cyc - b0, t0_cyc - a0, adr_trunc);
        end
        gpio_en = 1'b1;
        do_req(32'h3001_0020, GPIO_DAT, 2, 1'b0, "gpio");
        gpio_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        la_en = 1'b1;
        gpio_en = 1'b1;
        do_req(32'h3000_0040, LA_DAT, 2, 1'b1, "b2b_first");
        do_req(32'h3001_0044, GPIO_DAT, 2, 1'b0, "b2b_second");
        la_en = 1'b0;
        gpio_en = 1'b0;
    endtask

    task automatic test_ignore_other_ack();
        bit found;
        int g0;
        g0 = gpio_cyc;
        exp_q.push_back(T1_DAT);
        start_team1(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ignore_strobe got no team1 strobe want strobe");
        end
        gpio_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.wbs_ack_o !== 1'b0) begin
                errors++;
                $display("FAIL ignore_gpio_ack got host ack=%b want 0", bus.wbs_ack_o);
            end
        end
        gpio_force = 1'b0;
        team_force = 2'b01;
        @(posedge clk);
        #1 team_force = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== exp_q[0]) begin
            errors++;
            $display("FAIL ignore_team_ack got ack=%b dat=%h want 1/%h", bus.wbs_ack_o, bus.wbs_dat_o, exp_q[0]);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        checks++;
        if (tcnt !== 8'd0 || gpio_cyc !== g0) begin
            errors++;
            $display("FAIL ignore_side_effects got cnt=%0d gpio_stb=%0d want 0/0", tcnt, gpio_cyc - g0);
        end
    endtask

    task automatic test_abort();
        bit found;
        int k0;
        k0 = ack_total;
        start_team1(found);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        checks++;
        if (!found || designs_stb !== 2'b00) begin
            errors++;
            $display("FAIL abort_strobe got found=%b stb=%b want 1/00", found, designs_stb);
        end
        @(negedge clk);
        team_force = 2'b01;
        @(negedge clk);
        team_force = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        if (ack_total !== k0 || tcnt !== 8'd0) begin
            errors++;
            $display("FAIL abort_no_ack got acks=%0d cnt=%0d want 0/0", ack_total - k0, tcnt);
        end
        @(posedge clk);
        #1 gpio_en = 1'b1;
        do_req(32'h3001_0000, GPIO_DAT, 2, 1'b0, "abort_next_gpio");
        gpio_en = 1'b0;
    endtask

    task automatic test_timeout();
        int a0;
        a0 = t0_cyc;
        do_req(32'h3002_0004, 32'hDEAD0002, 16, 1'b0, "timeout");
        checks++;
        if ((t0_cyc - a0) !== 16 || tcnt !== 8'd1) begin
            errors++;
            $display("FAIL timeout_first got stb_cyc=%0d cnt=%0d want 16/1", t0_cyc - a0, tcnt);
        end
        for (int i = 0; i < 254; i++) begin
            do_req(32'h3002_0004, 32'hDEAD0002, -1, 1'b0, "timeout_rep");
        end
        checks++;
        if (tcnt !== 8'd255) begin
            errors++;
            $display("FAIL timeout_reach_255 got %0d want 255", tcnt);
        end
        for (int i = 0; i < 2; i++) begin
            do_req(32'h3003_0000, 32'hDEAD0003, 16, 1'b0, "timeout_sat");
        end
        checks++;
        if (tcnt !== 8'd255) begin
            errors++;
            $display("FAIL timeout_saturate got %0d want 255", tcnt);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit found;
        start_team1(found);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!found || {la_stb, gpio_stb, designs_stb, bus.wbs_ack_o, tcnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_busy got found=%b stb=%b ack=%b cnt=%0d want 1/00/0/0",
                     found, designs_stb, bus.wbs_ack_o, tcnt);
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 gpio_en = 1'b1;
        do_req(32'h3001_0004, GPIO_DAT, 2, 1'b0, "after_reset_gpio");
        gpio_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_la_read();
        test_unmapped();
        test_team2_and_gpio();
        test_back_to_back();
        test_ignore_other_ack();
        test_abort();
        test_timeout();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
